// File: rtl/xd_sync_debounce_pkg.sv
// Shared types and helpers for the synchroniser/debouncer slice.
// Holds default parameter values and the debounce counter width rule.
package xd_sync_debounce_pkg;

    localparam int DEF_CH        = 4;
    localparam int DEF_STAGES    = 2;
    localparam int DEF_DB_CYCLES = 4;

    // Registered edge pulses of one channel.
    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    // Counter must be able to represent 0..DB_CYCLES.
    function automatic int cnt_width(input int db_cycles);
        return $clog2(db_cycles + 1);
    endfunction

endpackage

// File: rtl/xd_sync_debounce_if.sv
// Level-input bundle: raw asynchronous levels in, accepted levels and edge pulses out.
// The design drives through the slave modport; the source/observer uses master.
interface xd_sync_debounce_if #(
    parameter int CH = 4
);
    logic [CH-1:0] sig_async;
    logic [CH-1:0] sig_sync;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          any;

    modport slave (
        input  sig_async,
        output sig_sync,
        output rise,
        output fall,
        output any
    );

    modport master (
        output sig_async,
        input  sig_sync,
        input  rise,
        input  fall,
        input  any
    );
endinterface

// File: rtl/xd_sync_debounce_ch.sv
// One channel: STAGES-deep synchroniser, persistence counter, accepted level and edge pulses.
// New level shows on o_level/o_rise/o_fall STAGES+DB_CYCLES edges after the input settles.
module xd_debounce_ch
    import xd_sync_debounce_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter int   DB_CYCLES = 4,
    parameter logic RST_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW       = cnt_width(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    logic [CW-1:0] r_cnt;
    logic          r_lvl;
    edge_t         r_edge;

    logic w_s;
    logic w_diff;
    logic w_accept;

    assign w_s      = r_sync[STAGES-1];
    assign w_diff   = w_s ^ r_lvl;
    assign w_accept = w_diff && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    // Any sample that agrees with the accepted level restarts the persistence count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lvl  <= RST_VAL;
            r_cnt  <= '0;
            r_edge <= '0;
        end else begin
            r_edge.rise <= w_accept &  w_s;
            r_edge.fall <= w_accept & ~w_s;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_lvl <= w_s;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_lvl;
    assign o_rise  = r_edge.rise;
    assign o_fall  = r_edge.fall;

endmodule

// File: rtl/xd_sync_debounce.sv
// Multi-channel synchroniser/debouncer: CH independent channels plus a combined event flag.
// Latency STAGES+DB_CYCLES edges per channel; no backpressure, outputs are levels and pulses.
module xd_sync_debounce
    import xd_sync_debounce_pkg::*;
#(
    parameter int            CH        = DEF_CH,
    parameter int            STAGES    = DEF_STAGES,
    parameter int            DB_CYCLES = DEF_DB_CYCLES,
    parameter logic [CH-1:0] RST_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    xd_sync_debounce_if.slave    bus
);

    logic [CH-1:0] w_sync;
    logic [CH-1:0] w_rise;
    logic [CH-1:0] w_fall;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        xd_debounce_ch #(
            .STAGES    (STAGES),
            .DB_CYCLES (DB_CYCLES),
            .RST_VAL   (RST_VAL[g])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_async (bus.sig_async[g]),
            .o_level (w_sync[g]),
            .o_rise  (w_rise[g]),
            .o_fall  (w_fall[g])
        );
    end

    assign bus.sig_sync = w_sync;
    assign bus.rise     = w_rise;
    assign bus.fall     = w_fall;
    assign bus.any      = |(w_rise | w_fall);

endmodule

// File: doc/xd_sync_debounce.md
XD_SYNC_DEBOUNCE -- requirements
Module: xd_sync_debounce

Interface
REQ-001 Parameter CH, default 4, number of independent input channels (>=1).
REQ-002 Parameter STAGES, default 2, synchroniser flop count per channel (>=2).
REQ-003 Parameter DB_CYCLES, default 4, consecutive cycles a new level must persist before acceptance (>=1; 1 = no filtering).
REQ-004 Parameter RST_VAL, default all-zero, CH-bit reset value of the accepted level per channel.
REQ-005 clk  input  1  single clock for all logic; one clock domain.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 sig_async  input  CH  asynchronous level inputs (buttons, switches, foreign-domain flags).
REQ-008 sig_sync  output  CH  synchronised, debounced level per channel.
REQ-009 rise  output  CH  one-cycle pulse per channel on accepted 0->1 transition.
REQ-010 fall  output  CH  one-cycle pulse per channel on accepted 1->0 transition.
REQ-011 any  output  1  OR-reduction of rise|fall, same cycle as those pulses.

Function
REQ-012 Each channel SHALL pass sig_async through a STAGES-deep flop chain; chain output s is the only sampled copy of the input used downstream.
REQ-013 Each channel SHALL hold accepted level lvl (drives sig_sync) and counter cnt of width $clog2(DB_CYCLES+1).
REQ-014 At each edge with s==lvl, cnt SHALL clear to 0 and lvl SHALL hold.
REQ-015 At each edge with s!=lvl and cnt<DB_CYCLES-1, cnt SHALL increment and lvl SHALL hold.
REQ-016 At each edge with s!=lvl and cnt==DB_CYCLES-1, lvl SHALL take s and cnt SHALL clear to 0.
REQ-017 rise/fall SHALL be registered, asserted in exactly the cycle sig_sync first shows the new level, and low otherwise.
REQ-018 Latency: input stable before edge E1 SHALL appear on sig_sync (and rise/fall) after edge E(STAGES+DB_CYCLES).
REQ-019 Any s excursion from lvl shorter than DB_CYCLES cycles SHALL be rejected with no output change and no pulse.
REQ-020 rise and fall SHALL never both be high on one channel in one cycle; at most one accepted transition per channel per DB_CYCLES cycles.
REQ-021 Channels SHALL be fully independent; simultaneous events on different channels SHALL pulse in the same cycle.
REQ-022 cnt SHALL never exceed DB_CYCLES-1 (no wrap).

Reset
REQ-023 While rst high: sync chains SHALL load RST_VAL, lvl=RST_VAL, cnt=0, rise=fall=0, any=0.
REQ-024 Reset mid-count SHALL discard the partial count; no pulse SHALL result from the aborted transition.
REQ-025 After release, an input differing from RST_VAL SHALL be treated as a normal transition (pulse after REQ-018 latency).

Structure
REQ-026 No shared package is required; counter width is a localparam derived from DB_CYCLES.
REQ-027 One sub-module xd_debounce_ch (single-channel chain, counter, lvl, edge pulses) SHALL be instantiated CH times via generate; top level adds only the any reduction.
REQ-028 Synchroniser flops SHALL carry an ASYNC_REG attribute; no logic between chain stages.

Verification (CH=4, STAGES=2, DB_CYCLES=4, RST_VAL=0 unless noted)
REQ-029 rst high 3 cycles with sig_async=4'b1111, then released -> sig_sync=0 and no pulses during reset; rise=4'b1111, any=1 for exactly one cycle at 6th edge after release; sig_sync=4'b1111 thereafter.
REQ-030 sig_async[0] high for 3 cycles then low -> sig_sync[0] stays 0, no rise/fall/any.
REQ-031 sig_async[1] 0->1 held 10 cycles then 1->0 held 10 -> rise[1] single pulse 6 edges after rising input, fall[1] single pulse 6 edges after falling input.
REQ-032 sig_sync[3]=1 then sig_async[2] 0->1 and sig_async[3] 1->0 same edge -> rise[2] and fall[3] in the same cycle, any=1 once.
REQ-033 sig_async[0] toggling every 2 cycles for 20 cycles, then stable 1 -> exactly one rise[0] pulse, 6 edges after final stabilisation.
REQ-034 rst pulsed 1 cycle when channel cnt=2 during transition -> cnt=0, no pulse at original acceptance time; repeat with DB_CYCLES=1 -> latency 3 edges.
